regbank_cmd_arbiter: RTL and testbench

- Shares one bank of NREG 16-bit datapath registers between two requesters, A and B.
- Each requester issues register commands (register select, FunSel, data) over a valid/ready handshake.
- The arbiter grants at most one command per cycle and drives the bank's per-register enables and its shared FunSel/data bus from registered outputs.
- After reset, it runs a one-cycle bank-clear sequence, then accepts commands. Sits between the control unit / DMA-style requesters and the register bank.

---
 rtl/regbank_cmd_arbiter.sv | 148 ++++++++++++++
 tb/tb_regbank_cmd_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_cmd_arbiter.sv
// regbank_cmd_arbiter: arbitrates two register-command requesters onto one
// shared register bank and runs a one-cycle bank clear after reset.
//
// Ports:
//   Clock, Reset (async, active-low), Stall (blocks new grants)
//   A_/B_Valid, _RegSel, _FunSel, _Data in; A_/B_Ready out (accept strobe)
//   RF_E (one-hot enable), RF_FunSel, RF_I: registered bank controls
//   Init_Done (clear finished), Last_Grant (0 = A, 1 = B)
//
// Macro REGBANK_ARB_RR_EN: defined selects round-robin tie-break;
// undefined selects fixed priority with A winning every tie.
module regbank_cmd_arbiter #(
  parameter  int NREG = 4,
  parameter  int W    = 16,
  localparam int RSW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            A_Valid,
  input  logic [RSW-1:0]  A_RegSel,
  input  logic [1:0]      A_FunSel,
  input  logic [W-1:0]    A_Data,
  output logic            A_Ready,
  input  logic            B_Valid,
  input  logic [RSW-1:0]  B_RegSel,
  input  logic [1:0]      B_FunSel,
  input  logic [W-1:0]    B_Data,
  output logic            B_Ready,
  output logic [NREG-1:0] RF_E,
  output logic [1:0]      RF_FunSel,
  output logic [W-1:0]    RF_I,
  output logic            Init_Done,
  output logic            Last_Grant
);

  localparam logic ST_RST_CLR = 1'b0;
  localparam logic ST_IDLE    = 1'b1;

  localparam logic [1:0] FS_LOAD  = 2'b10;
  localparam logic [1:0] FS_CLEAR = 2'b11;

  logic            state_q, state_d;
  logic [NREG-1:0] rf_e_q, rf_e_d;
  logic [1:0]      rf_funsel_q, rf_funsel_d;
  logic [W-1:0]    rf_i_q, rf_i_d;
  logic            init_done_q, init_done_d;
  logic            last_grant_q, last_grant_d;

  logic            tie_b;
  logic            can_grant;
  logic            gnt_a;
  logic            gnt_b;
  logic [RSW-1:0]  sel;
  logic [1:0]      fs;
  logic [W-1:0]    dat;
  logic [NREG-1:0] onehot;

`ifdef REGBANK_ARB_RR_EN
  // On a tie, the side that did not win last time goes next.
  assign tie_b = ~last_grant_q;
`else
  assign tie_b = 1'b0;
`endif

  assign can_grant = (state_q == ST_IDLE) & ~Stall;
  assign gnt_a = can_grant & A_Valid
               & (~B_Valid | ~tie_b);
  assign gnt_b = can_grant & B_Valid
               & (~A_Valid | tie_b);

  assign A_Ready = gnt_a;
  assign B_Ready = gnt_b;

  always_comb begin
    sel = '0;
    fs  = '0;
    dat = '0;
    unique case (1'b1)
      gnt_a: begin
        sel = A_RegSel;
        fs  = A_FunSel;
        dat = A_Data;
      end
      gnt_b: begin
        sel = B_RegSel;
        fs  = B_FunSel;
        dat = B_Data;
      end
      default: ;
    endcase
  end

  // Out-of-range selects match no bit, so the command is dropped.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel == RSW'(i)) onehot[i] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rf_e_d       = '0;
    rf_funsel_d  = rf_funsel_q;
    rf_i_d       = rf_i_q;
    init_done_d  = init_done_q;
    last_grant_d = last_grant_q;
    if (state_q == ST_RST_CLR) begin
      // Clear ignores Stall; it always takes exactly one cycle.
      rf_e_d      = '1;
      rf_funsel_d = FS_CLEAR;
      rf_i_d      = '0;
      init_done_d = 1'b1;
      state_d     = ST_IDLE;
    end else if (gnt_a | gnt_b) begin
      rf_e_d       = onehot;
      rf_funsel_d  = fs;
      rf_i_d       = (fs == FS_LOAD) ? dat : '0;
      last_grant_d = gnt_b;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_RST_CLR;
      rf_e_q       <= '0;
      rf_funsel_q  <= '0;
      rf_i_q       <= '0;
      init_done_q  <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rf_e_q       <= rf_e_d;
      rf_funsel_q  <= rf_funsel_d;
      rf_i_q       <= rf_i_d;
      init_done_q  <= init_done_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign RF_E       = rf_e_q;
  assign RF_FunSel  = rf_funsel_q;
  assign RF_I       = rf_i_q;
  assign Init_Done  = init_done_q;
  assign Last_Grant = last_grant_q;

endmodule

// File: tb/tb_regbank_cmd_arbiter.sv
// tb_regbank_cmd_arbiter: directed bench with a cycle model of the arbiter
// plus literal checks; a second NREG=5 instance covers out-of-range selects.
module tb_regbank_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;

  logic        a_valid = 1'b0;
  logic [1:0]  a_sel = '0;
  logic [1:0]  a_fs = '0;
  logic [15:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic [1:0]  b_sel = '0;
  logic [1:0]  b_fs = '0;
  logic [15:0] b_data = '0;

  logic        a_rdy, b_rdy;
  logic [3:0]  rf_e;
  logic [1:0]  rf_fs;
  logic [15:0] rf_i;
  logic        init_done, last_grant;

  // A 2-bit select cannot express an out-of-range index, so a 5-entry
  // bank (3-bit select) is used for those cases.
  logic        c_a_valid = 1'b0;
  logic [2:0]  c_a_sel = '0;
  logic [1:0]  c_a_fs = '0;
  logic [15:0] c_a_data = '0;
  logic        c_b_valid = 1'b0;
  logic [2:0]  c_b_sel = '0;
  logic [1:0]  c_b_fs = '0;
  logic [15:0] c_b_data = '0;
  logic        c_a_rdy, c_b_rdy;
  logic [4:0]  c_rf_e;
  logic [1:0]  c_rf_fs;
  logic [15:0] c_rf_i;
  logic        c_init_done, c_last_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regbank_cmd_arbiter #(.NREG(4), .W(16)) dut (
    .Clock(clk), .Reset(rst_n), .Stall(stall),
    .A_Valid(a_valid), .A_RegSel(a_sel),
    .A_FunSel(a_fs), .A_Data(a_data), .A_Ready(a_rdy),
    .B_Valid(b_valid), .B_RegSel(b_sel),
    .B_FunSel(b_fs), .B_Data(b_data), .B_Ready(b_rdy),
    .RF_E(rf_e), .RF_FunSel(rf_fs), .RF_I(rf_i),
    .Init_Done(init_done), .Last_Grant(last_grant)
  );

  regbank_cmd_arbiter #(.NREG(5), .W(16)) dut5 (
    .Clock(clk), .Reset(rst_n), .Stall(stall),
    .A_Valid(c_a_valid), .A_RegSel(c_a_sel),
    .A_FunSel(c_a_fs), .A_Data(c_a_data), .A_Ready(c_a_rdy),
    .B_Valid(c_b_valid), .B_RegSel(c_b_sel),
    .B_FunSel(c_b_fs), .B_Data(c_b_data), .B_Ready(c_b_rdy),
    .RF_E(c_rf_e), .RF_FunSel(c_rf_fs), .RF_I(c_rf_i),
    .Init_Done(c_init_done), .Last_Grant(c_last_grant)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Model state: what the bank controls must show this cycle.
  logic [3:0]  m_rf_e = '0;
  logic [1:0]  m_fs = '0;
  logic [15:0] m_i = '0;
  bit          m_init = 1'b0;
  bit          m_last_b = 1'b1;

  // Who must win this cycle, from the arbitration rules.
  function automatic void want(output bit ga, output bit gb);
    bit b_wins_tie;
    ga = 1'b0;
    gb = 1'b0;
    if (!rst_n || !m_init || stall) return;
`ifdef REGBANK_ARB_RR_EN
    b_wins_tie = !m_last_b;
`else
    b_wins_tie = 1'b0;
`endif
    if (a_valid && b_valid) begin
      if (b_wins_tie) gb = 1'b1;
      else ga = 1'b1;
    end else begin
      ga = a_valid;
      gb = b_valid;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit ga, gb;
    int s;
    if (!rst_n) begin
      m_rf_e = '0;
      m_fs = '0;
      m_i = '0;
      m_init = 1'b0;
      m_last_b = 1'b1;
    end else if (!m_init) begin
      m_rf_e = 4'hF;
      m_fs = 2'd3;
      m_i = '0;
      m_init = 1'b1;
    end else begin
      want(ga, gb);
      if (ga || gb) begin
        s = ga ? int'(a_sel) : int'(b_sel);
        m_fs = ga ? a_fs : b_fs;
        m_rf_e = 4'(1 << s);
        m_i = (m_fs == 2'd2) ? (ga ? a_data : b_data) : 16'd0;
        m_last_b = gb;
      end else begin
        m_rf_e = '0;
      end
    end
  end

  always @(negedge clk) begin
    bit ga, gb;
    want(ga, gb);
    chk("model a_ready", 32'(a_rdy), 32'(ga));
    chk("model b_ready", 32'(b_rdy), 32'(gb));
    chk("model rf_e", 32'(rf_e), 32'(m_rf_e));
    chk("model init_done", 32'(init_done), 32'(m_init));
    chk("model last_grant", 32'(last_grant), 32'(m_last_b));
    if (m_rf_e != 0 || !rst_n) begin
      chk("model rf_funsel", 32'(rf_fs), 32'(m_fs));
      chk("model rf_i", 32'(rf_i), 32'(m_i));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    bit exp_a, prev_a;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mid();
    chk("reset rf_e", 32'(rf_e), 0);
    chk("reset rf_funsel", 32'(rf_fs), 0);
    chk("reset rf_i", 32'(rf_i), 0);
    chk("reset init_done", 32'(init_done), 0);
    chk("reset last_grant", 32'(last_grant), 1);

    // release: clear cycle, then idle
    cyc(); rst_n = 1'b1;
    mid();
    chk("clr0 rf_e", 32'(rf_e), 0);
    chk("clr0 a_ready", 32'(a_rdy), 0);
    cyc(); mid();
    chk("clr rf_e", 32'(rf_e), 'hF);
    chk("clr funsel", 32'(rf_fs), 3);
    chk("clr rf_i", 32'(rf_i), 0);
    chk("clr init_done", 32'(init_done), 1);
    cyc(); mid();
    chk("post clr rf_e", 32'(rf_e), 0);

    // A load R2
    cyc();
    a_valid = 1'b1; a_sel = 2'd2; a_fs = 2'd2; a_data = 16'hBEEF;
    mid();
    chk("load a_ready", 32'(a_rdy), 1);
    cyc(); a_valid = 1'b0;
    mid();
    chk("load rf_e", 32'(rf_e), 'h4);
    chk("load funsel", 32'(rf_fs), 2);
    chk("load rf_i", 32'(rf_i), 'hBEEF);
    chk("load last_grant", 32'(last_grant), 0);
    chk("load a_ready off", 32'(a_rdy), 0);

    // B alone first so the tie sequence starts with A
    cyc();
    b_valid = 1'b1; b_sel = 2'd1; b_fs = 2'd0; b_data = 16'h0;
    mid();
    chk("b solo b_ready", 32'(b_rdy), 1);
    prev_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      a_valid = 1'b1; a_sel = 2'd0; a_fs = 2'd1;
      mid();
`ifdef REGBANK_ARB_RR_EN
      exp_a = (k % 2 == 0);
`else
      exp_a = 1'b1;
`endif
      chk("tie a_ready", 32'(a_rdy), 32'(exp_a));
      chk("tie b_ready", 32'(b_rdy), 32'(!exp_a));
      chk("tie rf_e", 32'(rf_e), prev_a ? 'h1 : 'h2);
      prev_a = exp_a;
    end
    cyc(); a_valid = 1'b0; b_valid = 1'b0;
    mid();
    chk("tie tail rf_e", 32'(rf_e), prev_a ? 'h1 : 'h2);

    // Stall three cycles with A waiting
    for (int k = 0; k < 3; k++) begin
      cyc();
      stall = 1'b1;
      a_valid = 1'b1; a_sel = 2'd3; a_fs = 2'd2; a_data = 16'h1234;
      mid();
      chk("stall a_ready", 32'(a_rdy), 0);
      chk("stall rf_e", 32'(rf_e), 0);
    end
    cyc(); stall = 1'b0;
    mid();
    chk("unstall a_ready", 32'(a_rdy), 1);
    cyc(); a_valid = 1'b0;
    mid();
    chk("unstall rf_e", 32'(rf_e), 'h8);
    chk("unstall rf_i", 32'(rf_i), 'h1234);

    // Out-of-range selects on the 5-entry instance
    cyc();
    c_a_valid = 1'b1; c_a_sel = 3'd0; c_a_fs = 2'd1;
    mid();
    chk("n5 a_ready", 32'(c_a_rdy), 1);
    cyc();
    c_a_valid = 1'b0;
    c_b_valid = 1'b1; c_b_sel = 3'd5; c_b_fs = 2'd3;
    mid();
    chk("n5 inc rf_e", 32'(c_rf_e), 'h01);
    chk("n5 last a", 32'(c_last_grant), 0);
    chk("n5 oor b_ready", 32'(c_b_rdy), 1);
    cyc();
    c_b_sel = 3'd4; c_b_fs = 2'd2; c_b_data = 16'h5A5A;
    mid();
    chk("n5 oor rf_e", 32'(c_rf_e), 0);
    chk("n5 oor last", 32'(c_last_grant), 1);
    chk("n5 r4 b_ready", 32'(c_b_rdy), 1);
    cyc();
    c_b_sel = 3'd7; c_b_fs = 2'd3;
    mid();
    chk("n5 r4 rf_e", 32'(c_rf_e), 'h10);
    chk("n5 r4 rf_i", 32'(c_rf_i), 'h5A5A);
    cyc(); c_b_valid = 1'b0;
    mid();
    chk("n5 sel7 rf_e", 32'(c_rf_e), 0);

    // Reset right after a grant cancels that issue
    cyc();
    a_valid = 1'b1; a_sel = 2'd3; a_fs = 2'd2; a_data = 16'hCAFE;
    mid();
    chk("pre rst a_ready", 32'(a_rdy), 1);
    cyc(); rst_n = 1'b0; a_valid = 1'b0;
    mid();
    chk("mid rst rf_e", 32'(rf_e), 0);
    chk("mid rst init_done", 32'(init_done), 0);
    cyc(); mid();
    chk("held rst rf_e", 32'(rf_e), 0);
    cyc();
    rst_n = 1'b1;
    a_valid = 1'b1; a_sel = 2'd2; a_fs = 2'd1;
    mid();
    chk("reclr a_ready", 32'(a_rdy), 0);
    chk("reclr0 rf_e", 32'(rf_e), 0);
    cyc(); mid();
    chk("reclr rf_e", 32'(rf_e), 'hF);
    chk("reclr funsel", 32'(rf_fs), 3);
    chk("reidle a_ready", 32'(a_rdy), 1);
    cyc(); a_valid = 1'b0;
    mid();
    chk("reissue rf_e", 32'(rf_e), 'h4);
    chk("reissue funsel", 32'(rf_fs), 1);
    cyc(); mid();
    chk("final rf_e", 32'(rf_e), 0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
